xdisp_scan: RTL and testbench
=============================

XDISP_SCAN -- requirements
Module: xdisp_scan

Interface
REQ-001 SHALL have parameter DATA_W, default 8: binary magnitude width, legal range 4..27.
REQ-002 SHALL have parameter NDIGITS, default 4: number of display digits, legal range 2..8. Digit NDIGITS-1 is the sign digit; digits 0..NDIGITS-2 are BCD digits.
REQ-003 SHALL have parameter SCAN_W, default 18: each digit stays active for 2^SCAN_W clk cycles.
REQ-004 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  unsigned magnitude
- wr_sgn  in  1  negative flag
- wr_dot  in  clog2(NDIGITS)  decimal-point digit index; 0 = no dot
- wr_msg  in  2  00 number, 01 "OP", 10 "VAL", 11 "Err"
- busy  out  1  conversion in progress
- disp_select  out  NDIGITS  active-low digit enable, one-hot
- disp_value  out  8  active-low segments; bit7 = dp

Function
REQ-005 SHALL accept a write only when wr_en=1 and busy=0, capturing wr_data, wr_sgn, wr_dot and wr_msg.
REQ-006 SHALL ignore wr_en while busy=1: no capture and no effect on the conversion in flight.
REQ-007 SHALL use FSM states IDLE, CONV and LOAD:
- IDLE -> CONV on an accepted write.
- CONV lasts exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble >4, then shifts one magnitude bit in, MSB first.
- CONV -> LOAD, which lasts 1 cycle.
- LOAD -> IDLE.
REQ-008 SHALL drive busy=1 from the cycle after acceptance through the LOAD cycle, i.e. DATA_W+1 cycles. A new write is accepted on the first cycle busy=0.
REQ-009 SHALL update the display registers (BCD, sgn, dot, msg, overflow) atomically in LOAD. The display SHALL never show a partial conversion.
REQ-010 SHALL set overflow when the magnitude > 10^(NDIGITS-1)-1. In number mode, overflow SHALL make all digits show '-'.
REQ-011 SHALL run a free prescaler counting 0..2^SCAN_W-1. On each wrap the digit index SHALL increment, wrapping NDIGITS-1 -> 0 (including non-power-of-two NDIGITS).
REQ-012 SHALL drive disp_select bit[index]=0 with all other bits 1, registered with no glitches.
REQ-013 SHALL use these segment codes (hex):
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
- '-'=BF, blank=FF, E=86, r=AF, O=C0, P=8C, V=C1, A=88, L=C7
REQ-014 SHALL, in number mode, show BCD nibble k on digit k (k < NDIGITS-1), with leading zeros blanked. Digit k>0 SHALL be blanked if it and all higher BCD digits are 0, unless k <= dot. Value 0 SHALL show "0" on digit 0 only.
REQ-015 SHALL show '-' on the sign digit when sgn=1 and magnitude≠0; otherwise the sign digit SHALL be blank. Negative zero SHALL show as blank.
REQ-016 SHALL clear bit7 on the digit whose index equals dot, but only when dot≠0, msg=00 and there is no overflow.
REQ-017 SHALL, in message mode, left-justify the characters from digit NDIGITS-1 downward: "OP" = O,P; "VAL" = V,A,L; "Err" = E,r,r. Remaining digits SHALL be blank, characters beyond digit 0 SHALL be truncated, and the dp SHALL be off.

Reset
REQ-018 SHALL, while rst=0, asynchronously clear:
- the FSM to IDLE
- busy, prescaler, digit index, shift registers and display registers
REQ-019 SHALL, after reset: disp_select = all ones except bit0 = 0; disp_value = C0 ("0"); busy = 0.
REQ-020 SHALL, on reset asserted mid-CONV, abort the conversion. After release the display SHALL show "0" and the next write SHALL be accepted.

Verification (NDIGITS=4, DATA_W=8, SCAN_W=2 unless stated)
REQ-021 SHALL cover: reset release -> disp_select=1110, disp_value=C0, busy=0; digit index cycles 0,1,2,3,0 every 4 cycles.
REQ-022 SHALL cover: write 173, sgn=1, dot=0 -> busy high 9 cycles; then d0=B0, d1=F8, d2=F9, d3=BF.
REQ-023 SHALL cover: write 5, sgn=0, dot=2 -> d0=92, d1=C0, d2=40, d3=FF; and write 0, sgn=1 -> d0=C0, d1..d3=FF.
REQ-024 SHALL cover: write 7, then wr_en pulse with data 99 three cycles later -> second write ignored; d0=F8, d1..d3=FF; a write of 99 on the first busy=0 cycle is accepted.
REQ-025 SHALL cover: msg=11 -> d3=86, d2=AF, d1=AF, d0=FF; msg=10 -> C1, 88, C7, FF.
REQ-026 SHALL cover: NDIGITS=3 instance, write 200 -> all three digits BF; rst=0 pulse during CONV -> busy=0 and d0=C0 after release.

Source files
------------

// File: rtl/xdisp_scan.sv
// xdisp_scan: binary-to-BCD converting, multiplexed 7-segment display driver
// with sign digit, decimal point, overflow dashes and fixed text messages.
module xdisp_scan #(
    parameter int DATA_W  = 8,
    parameter int NDIGITS = 4,
    parameter int SCAN_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_sgn,
    input  logic [$clog2(NDIGITS)-1:0] wr_dot,
    input  logic [1:0]                 wr_msg,
    output logic                       busy,
    output logic [NDIGITS-1:0]         disp_select,
    output logic [7:0]                 disp_value
);
    localparam int NB = NDIGITS - 1;
    localparam int IW = $clog2(NDIGITS);
    localparam int CW = $clog2(DATA_W);
    localparam logic [31:0] LIMIT = 32'(10**NB - 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mag;
    logic [4*NB-1:0]   bcd, bcd_adj, d_bcd;
    logic              p_sgn, p_ovf, d_sgn, d_ovf;
    logic [IW-1:0]     p_dot, d_dot, idx;
    logic [1:0]        p_msg, d_msg;
    logic [SCAN_W-1:0] pre;
    logic [NDIGITS-1:0] nz;
    logic [3:0]        dig;
    logic [7:0]        seg;
    logic              acc;

    function automatic logic [7:0] dig_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // p counts characters from the leftmost (sign) digit
    function automatic logic [7:0] msg_seg(input logic [1:0] m, input int p);
        logic [23:0] s;
        s = m == 2'b01 ? 24'hC08CFF : m == 2'b10 ? 24'hC188C7 : 24'h86AFAF;
        return p > 2 ? 8'hFF : s[8*(2-p) +: 8];
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Upper BCD digits are dropped during shifting; overflow masks that case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            mag   <= '0;
            bcd   <= '0;
            p_sgn <= 1'b0;
            p_ovf <= 1'b0;
            p_dot <= '0;
            p_msg <= '0;
            d_bcd <= '0;
            d_sgn <= 1'b0;
            d_ovf <= 1'b0;
            d_dot <= '0;
            d_msg <= '0;
        end else begin
            case (state)
                IDLE: if (wr_en) begin
                    state <= CONV;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    mag   <= wr_data;
                    bcd   <= '0;
                    p_sgn <= wr_sgn;
                    p_dot <= wr_dot;
                    p_msg <= wr_msg;
                    p_ovf <= {{(32-DATA_W){1'b0}}, wr_data} > LIMIT;
                end
                CONV: begin
                    {bcd, mag} <= {bcd_adj[4*NB-2:0], mag, 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W-1))
                        state <= LOAD;
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    d_bcd <= bcd;
                    d_sgn <= p_sgn;
                    d_ovf <= p_ovf;
                    d_dot <= p_dot;
                    d_msg <= p_msg;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        nz  = '0;
        acc = 1'b0;
        for (int i = NB-1; i >= 0; i--) begin
            acc   = acc | (d_bcd[4*i +: 4] != 4'd0);
            nz[i] = acc;
        end
    end

    assign dig = 4'(d_bcd >> {idx, 2'b00});

    always_comb begin
        seg = 8'hFF;
        if (d_msg != 2'b00)
            seg = msg_seg(d_msg, NB - int'(idx));
        else if (d_ovf)
            seg = 8'hBF;
        else if (idx == IW'(NB))
            seg = d_sgn && nz[0] ? 8'hBF : 8'hFF;
        else if (idx == '0 || nz[idx] || idx <= d_dot)
            seg = dig_seg(dig);
        if (d_msg == 2'b00 && !d_ovf && d_dot != '0 && d_dot == idx)
            seg[7] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre         <= '0;
            idx         <= '0;
            disp_select <= ~NDIGITS'(1);
            disp_value  <= 8'hC0;
        end else begin
            pre <= pre + 1'b1;
            if (&pre)
                idx <= idx == IW'(NDIGITS-1) ? '0 : idx + 1'b1;
            disp_select <= ~(NDIGITS'(1) << idx);
            disp_value  <= seg;
        end
    end
endmodule

// File: tb/tb_xdisp_scan.sv
// tb_xdisp_scan: scoreboard bench for xdisp_scan with 4-digit and 3-digit instances
module tb_xdisp_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst4, en4, sgn4, busy4;
  logic [7:0] data4, val4;
  logic [1:0] dot4, msg4;
  logic [3:0] sel4;
  logic       rst3, en3, sgn3, busy3;
  logic [7:0] data3, val3;
  logic [1:0] dot3, msg3;
  logic [2:0] sel3;
  xdisp_scan #(.DATA_W(8), .NDIGITS(4), .SCAN_W(2)) u4 (
    .clk(clk), .rst(rst4), .wr_en(en4), .wr_data(data4), .wr_sgn(sgn4),
    .wr_dot(dot4), .wr_msg(msg4), .busy(busy4), .disp_select(sel4), .disp_value(val4)
  );
  xdisp_scan #(.DATA_W(8), .NDIGITS(3), .SCAN_W(2)) u3 (
    .clk(clk), .rst(rst3), .wr_en(en3), .wr_data(data3), .wr_sgn(sgn3),
    .wr_dot(dot3), .wr_msg(msg3), .busy(busy3), .disp_select(sel3), .disp_value(val3)
  );
  int    q_kind[$], q_dut[$], q_arg[$], q_val[$];
  int    nvec = 0, nbad = 0, tmo = 0;
  string kname[4] = '{"digit", "busy", "select", "busylen"};
  function automatic void pop();
    void'(q_kind.pop_front());
    void'(q_dut.pop_front());
    void'(q_arg.pop_front());
    void'(q_val.pop_front());
    tmo = 0;
  endfunction
  always @(negedge clk) begin
    if (q_kind.size() != 0) begin
      logic [3:0] s;
      int         act;
      logic       hit;
      s   = q_dut[0] == 1 ? {1'b1, sel3} : sel4;
      hit = 1'b1;
      act = q_arg[0];
      if (q_kind[0] == 0) begin
        hit = s == ~(4'b0001 << q_arg[0]);
        act = int'(q_dut[0] == 1 ? val3 : val4);
      end else if (q_kind[0] == 1)
        act = int'(q_dut[0] == 1 ? busy3 : busy4);
      else if (q_kind[0] == 2)
        act = int'(s);
      if (hit) begin
        nvec++;
        if (act != q_val[0]) begin
          nbad++;
          $display("FAIL %s u%0d arg%0d: got %0h want %0h", kname[q_kind[0]],
                   q_dut[0] == 1 ? 3 : 4, q_arg[0], act, q_val[0]);
        end
        pop();
      end else if (tmo >= 64) begin
        nvec++;
        nbad++;
        $display("FAIL %s u%0d arg%0d: timeout waiting, want %0h", kname[q_kind[0]],
                 q_dut[0] == 1 ? 3 : 4, q_arg[0], q_val[0]);
        pop();
      end else
        tmo++;
    end
  end
  function automatic void push(input int k, input int u, input int a, input int v);
    q_kind.push_back(k);
    q_dut.push_back(u);
    q_arg.push_back(a);
    q_val.push_back(v);
  endfunction
  task automatic drain();
    int n = 0;
    while (q_kind.size() != 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic show(input int u, input int e0, input int e1, input int e2, input int e3);
    repeat (2) @(posedge clk);
    push(0, u, 0, e0);
    push(0, u, 1, e1);
    push(0, u, 2, e2);
    if (u == 0) push(0, u, 3, e3);
    drain();
  endtask
  task automatic wr(input int u, input int d, input int s, input int dt, input int m,
                    input bit pulse, input bit abort);
    int n = 0;
    if (u == 0) begin
      en4 = 1'b1; data4 = 8'(d); sgn4 = 1'(s); dot4 = 2'(dt); msg4 = 2'(m);
    end else begin
      en3 = 1'b1; data3 = 8'(d); sgn3 = 1'(s); dot3 = 2'(dt); msg3 = 2'(m);
    end
    @(negedge clk);
    en4 = 1'b0;
    en3 = 1'b0;
    while ((u == 0 ? busy4 : busy3) && n < 100) begin
      if (pulse) begin
        en4   = n == 2;
        data4 = 8'd99;
      end
      if (abort && n == 2) rst3 = 1'b0;
      n++;
      @(negedge clk);
    end
    en4  = 1'b0;
    rst3 = 1'b1;
    if (!abort) push(3, u, n, 9);
  endtask
  int exp_sel[5] = '{14, 13, 11, 7, 14};
  initial begin
    rst4 = 1'b0; rst3 = 1'b0;
    en4 = 1'b0; data4 = '0; sgn4 = 1'b0; dot4 = '0; msg4 = '0;
    en3 = 1'b0; data3 = '0; sgn3 = 1'b0; dot3 = '0; msg3 = '0;
    @(posedge clk);
    #1;
    push(1, 0, 0, 0);
    push(2, 0, 0, 14);
    push(0, 0, 0, 'hC0);
    push(1, 1, 0, 0);
    push(2, 1, 0, 14);
    push(0, 1, 0, 'hC0);
    drain();
    rst4 = 1'b1;
    rst3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      push(2, 0, 0, exp_sel[i]);
      repeat (3) @(posedge clk);
    end
    drain();
    @(negedge clk);
    wr(0, 173, 1, 0, 0, 0, 0); show(0, 'hB0, 'hF8, 'hF9, 'hBF);
    wr(0, 5, 0, 2, 0, 0, 0);   show(0, 'h92, 'hC0, 'h40, 'hFF);
    wr(0, 0, 1, 0, 0, 0, 0);   show(0, 'hC0, 'hFF, 'hFF, 'hFF);
    wr(0, 7, 0, 0, 0, 1, 0);   show(0, 'hF8, 'hFF, 'hFF, 'hFF);
    wr(0, 12, 0, 0, 0, 0, 0);
    wr(0, 99, 0, 0, 0, 0, 0);  show(0, 'h90, 'h90, 'hFF, 'hFF);
    wr(0, 5, 0, 2, 3, 0, 0);   show(0, 'hFF, 'hAF, 'hAF, 'h86);
    wr(0, 5, 0, 2, 2, 0, 0);   show(0, 'hFF, 'hC7, 'h88, 'hC1);
    wr(1, 200, 0, 0, 0, 0, 0); show(1, 'hBF, 'hBF, 'hBF, 0);
    wr(1, 42, 1, 0, 0, 0, 0);  show(1, 'hA4, 'h99, 'hBF, 0);
    wr(1, 57, 0, 0, 0, 0, 1);
    push(1, 1, 0, 0);
    show(1, 'hC0, 'hFF, 'hFF, 0);
    wr(1, 31, 0, 0, 0, 0, 0);  show(1, 'hF9, 'hB0, 'hFF, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
